// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-RAM port arbiter: CPU fixed priority, aux anti-starvation and bounded lock bursts
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int MAX_LOCK   = 8
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic        cpu_half,
    input  logic        cpu_uext,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    input  logic        aux_req,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic        aux_we,
    input  logic        aux_byte,
    input  logic        aux_half,
    input  logic        aux_uext,
    input  logic        aux_lock,
    output logic        aux_gnt,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_byte,
    output logic        ram_half,
    output logic        ram_uext,
    input  logic [31:0] ram_rdata,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [4:0] LOCK_LIM   = 5'(MAX_LOCK);

    logic [3:0] wait_cnt;
    logic [3:0] lock_cnt;
    logic       locked;
    logic [4:0] lock_inc;
    logic       rd_gnt;

    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (locked && aux_req)
            aux_gnt = 1'b1;
        else if (aux_req && wait_cnt == STARVE_LIM)
            aux_gnt = 1'b1;
        else if (cpu_req)
            cpu_gnt = 1'b1;
        else if (aux_req)
            aux_gnt = 1'b1;
    end

    // With no grant the CPU fields are presented, but the write strobe stays low.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_byte  = cpu_byte;
        ram_half  = cpu_half;
        ram_uext  = cpu_uext;
        if (aux_gnt) begin
            ram_addr  = aux_addr;
            ram_wdata = aux_wdata;
            ram_byte  = aux_byte;
            ram_half  = aux_half;
            ram_uext  = aux_uext;
        end
    end

    assign ram_we    = (cpu_gnt & cpu_we) | (aux_gnt & aux_we);
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign rd_gnt    = (cpu_gnt | aux_gnt) & ~ram_we;
    assign lock_inc  = {1'b0, lock_cnt} + 5'd1;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            wait_cnt  <= 4'd0;
            lock_cnt  <= 4'd0;
            locked    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            if (aux_req && !aux_gnt)
                wait_cnt <= (wait_cnt == STARVE_LIM) ? wait_cnt : wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;

            // Saturate so an unlocked aux stream holding aux_lock cannot wrap into a fresh burst.
            if (aux_gnt && aux_lock)
                lock_cnt <= (lock_cnt == 4'hF) ? lock_cnt : lock_inc[3:0];
            else
                lock_cnt <= 4'd0;

            locked <= aux_gnt & aux_lock & (lock_inc < LOCK_LIM);

            rsp_valid <= rd_gnt;
            if (rd_gnt) begin
                rsp_id    <= aux_gnt;
                rsp_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        CLR;
    logic        cpu_req, cpu_we, cpu_byte, cpu_half, cpu_uext;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall;
    logic        aux_req, aux_we, aux_byte, aux_half, aux_uext, aux_lock;
    logic [31:0] aux_addr, aux_wdata;
    logic        aux_gnt;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, ram_byte, ram_half, ram_uext;
    logic        rsp_valid, rsp_id;
    logic [31:0] rsp_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(4), .MAX_LOCK(8)) dut (
        .clk(clk), .CLR(CLR),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_byte(cpu_byte), .cpu_half(cpu_half), .cpu_uext(cpu_uext),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_we(aux_we),
        .aux_byte(aux_byte), .aux_half(aux_half), .aux_uext(aux_uext), .aux_lock(aux_lock),
        .aux_gnt(aux_gnt),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_byte(ram_byte), .ram_half(ram_half), .ram_uext(ram_uext),
        .ram_rdata(ram_rdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata)
    );

    // Little-endian byte RAM, 256 bytes, write at clock edge, combinational read.
    logic [7:0] mem [0:255];
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ram_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[a0] <= ram_wdata[7:0];
            if (!ram_byte) mem[a1] <= ram_wdata[15:8];
            if (!ram_byte && !ram_half) begin
                mem[a2] <= ram_wdata[23:16];
                mem[a3] <= ram_wdata[31:24];
            end
        end
    end

    always_comb begin
        ram_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
        if (ram_byte)
            ram_rdata = ram_uext ? {24'd0, mem[a0]} : {{24{mem[a0][7]}}, mem[a0]};
        else if (ram_half)
            ram_rdata = ram_uext ? {16'd0, mem[a1], mem[a0]} : {{16{mem[a1][7]}}, mem[a1], mem[a0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_half = 0; cpu_uext = 0;
        aux_req = 0; aux_we = 0; aux_byte = 0; aux_half = 0; aux_uext = 0; aux_lock = 0;
    endtask

    initial begin
        CLR = 1;
        idle_all();
        cpu_addr = 0; cpu_wdata = 0; aux_addr = 0; aux_wdata = 0;

        // Reset state
        #3;
        check("rst_cpu_gnt_idle", cpu_gnt, 0);
        cpu_req = 1;
        #1;
        check("rst_cpu_gnt_req", cpu_gnt, 1);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        cpu_req = 0;
        @(negedge clk);
        CLR = 0;

        // CPU word store 0xDEADBEEF at 0x10
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1;
        check("st_cpu_gnt", cpu_gnt, 1);
        check("st_ram_we", ram_we, 1);

        // CPU read of 0x10
        step();
        cpu_we = 0;
        #1;
        check("rd_cpu_gnt", cpu_gnt, 1);
        check("rd_ram_addr", ram_addr, 32'h10);
        check("rd_ram_we", ram_we, 0);
        check("st_no_rsp", rsp_valid, 0);
        step();
        cpu_req = 0;
        #1;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_id", rsp_id, 0);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        check("idle_ram_we", ram_we, 0);
        check("idle_cpu_gnt", cpu_gnt, 0);
        check("idle_aux_gnt", aux_gnt, 0);
        step();
        #1;
        check("idle_rsp_valid", rsp_valid, 0);

        // Starvation: both requesters read continuously
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) begin
                cpu_req = 1; cpu_addr = 32'h10;
                aux_req = 1; aux_addr = 32'h10; aux_we = 0;
            end
            #1;
            check($sformatf("starve_cpu_gnt_c%0d", c), cpu_gnt, (c != 4));
            check($sformatf("starve_aux_gnt_c%0d", c), aux_gnt, (c == 4));
            check($sformatf("starve_stall_c%0d", c), cpu_stall, (c == 4));
            if (c == 5) begin
                check("starve_rsp_id_aux", rsp_id, 1);
                check("starve_rsp_rdata_aux", rsp_rdata, 32'hDEADBEEF);
            end
        end
        step();
        idle_all();

        // Lock burst: aux locks from cycle 0, CPU arrives in cycle 2
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 0) begin aux_req = 1; aux_lock = 1; end
            if (c == 2) cpu_req = 1;
            #1;
            check($sformatf("lock_aux_gnt_c%0d", c), aux_gnt, (c <= 7));
            check($sformatf("lock_cpu_gnt_c%0d", c), cpu_gnt, (c >= 8));
            check($sformatf("lock_stall_c%0d", c), cpu_stall, (c >= 2 && c <= 7));
        end
        step();
        idle_all();

        // Aux byte store then CPU unsigned byte load
        step();
        aux_req = 1; aux_we = 1; aux_byte = 1; aux_addr = 32'h23; aux_wdata = 32'hAB;
        #1;
        check("bst_aux_gnt", aux_gnt, 1);
        check("bst_ram_we", ram_we, 1);
        check("bst_ram_byte", ram_byte, 1);
        check("bst_ram_addr", ram_addr, 32'h23);
        check("bst_ram_wdata", ram_wdata, 32'hAB);
        step();
        idle_all();
        cpu_req = 1; cpu_addr = 32'h23; cpu_byte = 1; cpu_uext = 1;
        #1;
        check("bst_no_rsp", rsp_valid, 0);
        check("bld_cpu_gnt", cpu_gnt, 1);
        check("bld_ram_uext", ram_uext, 1);
        step();
        cpu_req = 0;
        #1;
        check("bld_rsp_valid", rsp_valid, 1);
        check("bld_rsp_rdata", rsp_rdata, 32'h000000AB);
        step();
        idle_all();

        // Reset mid-burst
        step();
        aux_req = 1; aux_lock = 1; aux_addr = 32'h10;
        step();
        cpu_req = 1; cpu_addr = 32'h10; cpu_byte = 0; cpu_uext = 0;
        #1;
        check("mrst_aux_gnt", aux_gnt, 1);
        check("mrst_stall", cpu_stall, 1);
        check("mrst_rsp_pre", rsp_valid, 1);
        #1;
        CLR = 1;
        #1;
        check("mrst_rsp_valid", rsp_valid, 0);
        check("mrst_rsp_id", rsp_id, 0);
        check("mrst_rsp_rdata", rsp_rdata, 0);
        check("mrst_cpu_gnt", cpu_gnt, 1);
        check("mrst_aux_gnt_off", aux_gnt, 0);
        @(negedge clk);
        CLR = 0;
        #1;
        check("mrst_rel_cpu_gnt", cpu_gnt, 1);
        step();
        check("mrst_next_cpu_gnt", cpu_gnt, 1);
        check("mrst_next_rsp_id", rsp_id, 0);
        check("mrst_next_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        idle_all();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
